// File: rtl/pseudo_spi_rx_intf.sv
// Pseudo-SPI read-back interface: parallel-loads the analog scan chain, shifts it out
// with two-phase clocks and writes the assembled words to SRAM. Optional macro: PSEUDO_SPI_RX_MSB_FIRST_EN.
module pseudo_spi_rx_intf #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 10,
  parameter int RESERVED_DATA_LEN = 8,
  parameter int SEL_CYCLES        = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic                         SPI_SI,
  output logic                         SCLK1,
  output logic                         SCLK2,
  output logic                         SEL,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] PO,
  output logic                         CEN,
  output logic                         WEN,
  output logic                         spi_MUX,
  output logic                         spi_is_done
);

  localparam int SEL_W = (SEL_CYCLES > 1) ? $clog2(SEL_CYCLES) : 1;
  localparam int BIT_W = (MEMORY_DATA_WIDTH > 1) ? $clog2(MEMORY_DATA_WIDTH) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SEL_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MEMORY_DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, GAP, SHIFT, STORE, DONE} state_t;

  state_t                         state;
  logic [SEL_W-1:0]               sel_cnt;
  logic [2:0]                     phase;
  logic [BIT_W-1:0]               bit_cnt;
  logic [RESERVED_DATA_LEN-1:0]   word_idx;
  logic [RESERVED_DATA_LEN-1:0]   next_idx;
  logic [RESERVED_DATA_LEN-1:0]   len_lat;
  logic [MEMORY_ADDR_WIDTH-1:0]   addr_lat;
  logic [MEMORY_DATA_WIDTH-1:0]   shreg;

  function automatic logic [MEMORY_DATA_WIDTH-1:0] shift_in(
    input logic [MEMORY_DATA_WIDTH-1:0] cur,
    input logic                         b
  );
`ifdef PSEUDO_SPI_RX_MSB_FIRST_EN
    return {cur[MEMORY_DATA_WIDTH-2:0], b};
`else
    return {b, cur[MEMORY_DATA_WIDTH-1:1]};
`endif
  endfunction

  assign next_idx = word_idx + RESERVED_DATA_LEN'(1);

  // Control FSM; every output is registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      sel_cnt     <= '0;
      phase       <= '0;
      bit_cnt     <= '0;
      word_idx    <= '0;
      SCLK1       <= 1'b0;
      SCLK2       <= 1'b0;
      SEL         <= 1'b0;
      A           <= '0;
      PO          <= '0;
      CEN         <= 1'b1;
      WEN         <= 1'b1;
      spi_MUX     <= 1'b0;
      spi_is_done <= 1'b0;
    end else if (state != IDLE && !BGN) begin
      // Abort: a partially shifted word is simply dropped; A/PO keep the last write.
      state       <= IDLE;
      SCLK1       <= 1'b0;
      SCLK2       <= 1'b0;
      SEL         <= 1'b0;
      CEN         <= 1'b1;
      WEN         <= 1'b1;
      spi_MUX     <= 1'b0;
      spi_is_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (BGN) begin
            word_idx <= '0;
            spi_MUX  <= 1'b1;
            if (DATA_LEN == '0) begin
              state <= DONE;
            end else begin
              state   <= LOAD;
              SEL     <= 1'b1;
              sel_cnt <= '0;
            end
          end
        end
        LOAD: begin
          if (sel_cnt == SEL_LAST) begin
            state <= GAP;
            SEL   <= 1'b0;
          end else begin
            sel_cnt <= sel_cnt + SEL_W'(1);
          end
        end
        GAP: begin
          state   <= SHIFT;
          phase   <= 3'd0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          case (phase)
            3'd0: begin
              SCLK1 <= 1'b1;
              phase <= 3'd1;
            end
            3'd1: begin
              SCLK1 <= 1'b0;
              phase <= 3'd2;
            end
            3'd2: begin
              SCLK2 <= 1'b1;
              phase <= 3'd3;
            end
            3'd3: begin
              SCLK2 <= 1'b0;
              phase <= 3'd4;
            end
            default: begin
              phase <= 3'd0;
              if (bit_cnt == BIT_LAST) begin
                state <= STORE;
                CEN   <= 1'b0;
                WEN   <= 1'b0;
                A     <= addr_lat + MEMORY_ADDR_WIDTH'(word_idx);
                PO    <= shreg;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          endcase
        end
        STORE: begin
          CEN      <= 1'b1;
          WEN      <= 1'b1;
          word_idx <= next_idx;
          if (next_idx == len_lat) begin
            state <= DONE;
          end else begin
            state   <= SHIFT;
            phase   <= 3'd0;
            bit_cnt <= '0;
          end
        end
        DONE: begin
          spi_is_done <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Datapath: start parameters are captured once, serial data sampled in phase 0.
  always_ff @(posedge CLK) begin
    if (state == IDLE && BGN) begin
      addr_lat <= ADDR_BGN;
      len_lat  <= DATA_LEN;
    end
    if (state == SHIFT && phase == 3'd0 && BGN) begin
      shreg <= shift_in(shreg, SPI_SI);
    end
  end

endmodule
